// File: rtl/multdiv_seq.sv
// Multicycle signed 32-bit multiply (radix-4 Booth) / divide (non-restoring) unit.
// Optional MULTDIV_EARLY_EXIT_EN: zero-operand multiply and divide-by-zero finish after one edge.
module multdiv_seq #(
    parameter int MUL_ITERS = 16,
    parameter int DIV_ITERS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] MUL_RUN = 2'd1;
    localparam logic [1:0] DIV_RUN = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

`ifdef MULTDIV_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    logic [1:0]  state;
    logic [5:0]  count;
    // Multiply: {acc[32:0], multiplier[31:0]}; divide: {remainder[32:0], quotient[31:0]}
    logic [64:0] prod;
    logic        qm1;
    logic [31:0] mcand;      // multiplicand, or divisor magnitude
    logic        qneg, div0, divovf, zero_op;

    logic        start_mul, start_div;
    logic [31:0] abs_a, abs_b;
    logic [33:0] a1, a2, addend, sum;
    logic [64:0] mul_next;
    logic [32:0] rsh, dv33, rnew;
    logic [64:0] div_next;

    assign start_mul = ctrl_MULT & ~ctrl_DIV;
    assign start_div = ctrl_DIV & ~ctrl_MULT;
    assign abs_a = data_operandA[31] ? -data_operandA : data_operandA;
    assign abs_b = data_operandB[31] ? -data_operandB : data_operandB;

    // Booth step: the partial-product sum needs 34 bits for +-2A, but after the
    // arithmetic shift by 2 it always fits back into the 33-bit accumulator.
    assign a1 = {{2{mcand[31]}}, mcand};
    assign a2 = a1 << 1;

    always_comb begin
        addend = '0;
        case ({prod[1:0], qm1})
            3'b001, 3'b010: addend = a1;
            3'b011:         addend = a2;
            3'b100:         addend = -a2;
            3'b101, 3'b110: addend = -a1;
            default:        addend = '0;
        endcase
    end

    assign sum      = {prod[64], prod[64:32]} + addend;
    assign mul_next = {sum[33], sum, prod[31:2]};

    // Non-restoring step; quotient bit is set when the new remainder is non-negative
    assign rsh      = {prod[63:32], prod[31]};
    assign dv33     = {1'b0, mcand};
    assign rnew     = prod[64] ? rsh + dv33 : rsh - dv33;
    assign div_next = {rnew, prod[30:0], ~rnew[32]};

    assign data_resultRDY = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            prod           <= '0;
            qm1            <= 1'b0;
            mcand          <= '0;
            qneg           <= 1'b0;
            div0           <= 1'b0;
            divovf         <= 1'b0;
            zero_op        <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
        end else if (start_mul) begin
            state   <= MUL_RUN;
            count   <= '0;
            mcand   <= data_operandA;
            prod    <= {33'd0, data_operandB};
            qm1     <= 1'b0;
            zero_op <= (data_operandA == 32'd0) || (data_operandB == 32'd0);
        end else if (start_div) begin
            state   <= DIV_RUN;
            count   <= '0;
            mcand   <= abs_b;
            prod    <= {33'd0, abs_a};
            qm1     <= 1'b0;
            qneg    <= data_operandA[31] ^ data_operandB[31];
            div0    <= (data_operandB == 32'd0);
            divovf  <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            zero_op <= (data_operandB == 32'd0);
        end else begin
            case (state)
                MUL_RUN: begin
                    if (EARLY_EXIT && zero_op) begin
                        state          <= DONE;
                        data_result    <= '0;
                        data_exception <= 1'b0;
                    end else if (count == 6'(MUL_ITERS)) begin
                        state          <= DONE;
                        data_result    <= prod[31:0];
                        data_exception <= (prod[63:32] != {32{prod[31]}});
                    end else begin
                        prod  <= mul_next;
                        qm1   <= prod[1];
                        count <= count + 6'd1;
                    end
                end
                DIV_RUN: begin
                    if ((EARLY_EXIT && zero_op) || (count == 6'(DIV_ITERS))) begin
                        state <= DONE;
                        if (div0) begin
                            data_result    <= '0;
                            data_exception <= 1'b1;
                        end else if (divovf) begin
                            data_result    <= 32'h8000_0000;
                            data_exception <= 1'b1;
                        end else begin
                            data_result    <= qneg ? -prod[31:0] : prod[31:0];
                            data_exception <= 1'b0;
                        end
                    end else begin
                        prod  <= div_next;
                        count <= count + 6'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_seq.sv
// Self-checking bench for multdiv_seq: directed cases, abort/reset/both-start
// scenarios and randomized operations against a plain-arithmetic reference model.
module tb_multdiv_seq;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY;

    int n_cmp = 0;
    int n_bad = 0;

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    // Reference model: signed arithmetic straight from the operation definitions
    function automatic void model(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (mul) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p[63:32] != {32{p[31]}});
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endfunction

    function automatic int exp_lat(input bit mul, input logic [31:0] a, input logic [31:0] b);
`ifdef MULTDIV_EARLY_EXIT_EN
        if (mul && (a == 0 || b == 0)) return 1;
        if (!mul && b == 0) return 1;
`endif
        return mul ? 17 : 33;
    endfunction

    // Issues one operation and measures it; checks are done by the callers.
    task automatic do_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic exc,
                         output logic rdy_after);
        @(negedge clock);
        data_operandA = a; data_operandB = b;
        ctrl_MULT = mul;   ctrl_DIV = !mul;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;  ctrl_DIV = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom;
        lat = 0;
        while (!data_resultRDY && lat < 100) begin
            @(posedge clock); lat++;
            @(negedge clock);
        end
        res = data_result;
        exc = data_exception;
        @(posedge clock);
        @(negedge clock);
        rdy_after = data_resultRDY;
    endtask

    task automatic test_reset;
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got res=%h exc=%b rdy=%b, want all 0",
                     data_result, data_exception, data_resultRDY);
        end
        reset = 1'b0;
    endtask

    task automatic test_directed;
        logic [31:0] ta [8] = '{32'd7, 32'h0001_0000, 32'h8000_0000, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'h8000_0000, 32'd0};
        logic [31:0] tb [8] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'd2,
                                32'd7, 32'd0, 32'hFFFF_FFFF, 32'd5};
        bit          tm [8] = '{1, 1, 1, 0, 0, 0, 0, 1};
        logic [31:0] tr [8] = '{32'hFFFF_FFEB, 32'd0, 32'h8000_0000, 32'hFFFF_FFFD,
                                32'd14, 32'd0, 32'h8000_0000, 32'd0};
        logic        te [8] = '{0, 1, 0, 0, 0, 1, 1, 0};
        int lat; logic [31:0] res; logic exc, after;
        for (int i = 0; i < 8; i++) begin
            do_op(tm[i], ta[i], tb[i], lat, res, exc, after);
            n_cmp++;
            if (lat !== exp_lat(tm[i], ta[i], tb[i])) begin
                n_bad++;
                $display("FAIL dir%0d_latency: got %0d, want %0d", i, lat, exp_lat(tm[i], ta[i], tb[i]));
            end
            n_cmp++;
            if (res !== tr[i]) begin
                n_bad++;
                $display("FAIL dir%0d_result: got %h, want %h", i, res, tr[i]);
            end
            n_cmp++;
            if (exc !== te[i]) begin
                n_bad++;
                $display("FAIL dir%0d_exception: got %b, want %b", i, exc, te[i]);
            end
            n_cmp++;
            if (after !== 1'b0) begin
                n_bad++;
                $display("FAIL dir%0d_rdy_single_pulse: rdy after done=%b, want 0", i, after);
            end
        end
    endtask

    task automatic test_abort;
        bit seen = 0;
        int lat = 0;
        @(negedge clock);
        data_operandA = 32'd100; data_operandB = 32'd7; ctrl_DIV = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) seen = 1;
        end
        data_operandA = 32'd6; data_operandB = 32'd7; ctrl_MULT = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        while (!data_resultRDY && lat < 100) begin
            @(posedge clock); lat++;
            @(negedge clock);
        end
        n_cmp++;
        if (seen || lat !== 17) begin
            n_bad++;
            $display("FAIL abort_latency: early_rdy=%0d restart_lat=%0d, want 0 and 17", seen, lat);
        end
        n_cmp++;
        if (data_result !== 32'd42 || data_exception !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_result: got %h/%b, want 0000002a/0", data_result, data_exception);
        end
        @(negedge clock);
    endtask

    task automatic test_reset_midop;
        bit seen = 0;
        @(negedge clock);
        data_operandA = 32'h0001_2345; data_operandB = 32'h0000_0777; ctrl_MULT = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (4) begin @(posedge clock); @(negedge clock); end
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        n_cmp++;
        if ({data_result, data_exception, data_resultRDY} !== 34'd0) begin
            n_bad++;
            $display("FAIL midop_reset_outputs: got res=%h exc=%b rdy=%b, want all 0",
                     data_result, data_exception, data_resultRDY);
        end
        repeat (40) begin
            @(posedge clock); @(negedge clock);
            if (data_resultRDY) seen = 1;
        end
        n_cmp++;
        if (seen || data_result !== 32'd0) begin
            n_bad++;
            $display("FAIL midop_reset_no_rdy: rdy_seen=%0d res=%h, want 0 and 0", seen, data_result);
        end
    endtask

    task automatic test_both_start;
        bit seen = 0;
        int lat = 0;
        int l2; logic [31:0] res; logic exc, after;
        do_op(1'b1, 32'd3, 32'd5, l2, res, exc, after);
        @(negedge clock);
        data_operandA = 32'd50; data_operandB = 32'd2; ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        repeat (40) begin
            @(posedge clock); @(negedge clock);
            if (data_resultRDY) seen = 1;
        end
        n_cmp++;
        if (seen || data_result !== 32'd15) begin
            n_bad++;
            $display("FAIL both_idle: rdy_seen=%0d res=%h, want 0 and 0000000f", seen, data_result);
        end
        // Both high during a running multiply must not disturb it
        @(negedge clock);
        data_operandA = 32'd9; data_operandB = 32'd9; ctrl_MULT = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT = 1'b0;
        repeat (2) begin @(posedge clock); lat++; @(negedge clock); end
        data_operandA = 32'd4; data_operandB = 32'd4; ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
        @(posedge clock); lat++;
        @(negedge clock);
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        while (!data_resultRDY && lat < 100) begin
            @(posedge clock); lat++;
            @(negedge clock);
        end
        n_cmp++;
        if (lat !== 17 || data_result !== 32'd81) begin
            n_bad++;
            $display("FAIL both_running: lat=%0d res=%h, want 17 and 00000051", lat, data_result);
        end
        @(negedge clock);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'h8000_0000;
            2:       v = 32'hFFFF_FFFF;
            3, 4:    v = $urandom >> $urandom_range(8, 30);
            5:       v = -($urandom >> $urandom_range(8, 30));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_random;
        int lat; logic [31:0] res, a, b, er; logic exc, after, ee; bit mul;
        for (int i = 0; i < 30; i++) begin
            mul = $urandom_range(0, 1);
            a = pick_operand();
            b = pick_operand();
            model(mul, a, b, er, ee);
            do_op(mul, a, b, lat, res, exc, after);
            n_cmp++;
            if (res !== er || exc !== ee || lat !== exp_lat(mul, a, b) || after !== 1'b0) begin
                n_bad++;
                $display("FAIL rand%0d_%s: a=%h b=%h got res=%h exc=%b lat=%0d rdy_after=%b, want res=%h exc=%b lat=%0d rdy_after=0",
                         i, mul ? "mul" : "div", a, b, res, exc, lat, after, er, ee, exp_lat(mul, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_abort();
        test_reset_midop();
        test_both_start();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end
endmodule
